pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
//
// PURPOSE
//  Parametrised elastic pipeline stage register, the successor to the fixed IF_ID/ID_EX/EX_MEM/MEM_WB latches.
//  Carries a DATA_W payload with valid/ready handshakes on both sides, plus a 2-entry skid buffer so in_ready is flop-driven.
//  Supports synchronous flush (branch/jump squash) and inserts all-zero bubbles (MIPS NOP) when empty.
//  One instance sits between each pair of CPU stages; the hazard unit drives out_ready/flush.
//
// PARAMETERS
//  DATA_W    32   payload width (instr + PC + control bundle packed by caller)
//  BUBBLE    '0   out_data value while out_valid=0 (default = NOP encoding)
//  CNT_W     32   statistics counter width (used only with PIPE_STAGE_STATS_EN)
//
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  flush        in   1       synchronous squash of all held and incoming entries
//  in_valid     in   1       upstream payload valid
//  in_ready     out  1       stage can accept; decoded from state flops only
//  in_data      in   DATA_W  upstream payload
//  out_valid    out  1       out_data holds a live entry
//  out_ready    in   1       downstream accepts (deassert = stall)
//  out_data     out  DATA_W  head entry; BUBBLE when out_valid=0
//  stall_cnt    out  CNT_W   [PIPE_STAGE_STATS_EN only] cycles with out_valid & !out_ready
//  flush_cnt    out  CNT_W   [PIPE_STAGE_STATS_EN only] live entries discarded by flush
//
// BEHAVIOUR
//  - Reset (async, rst=1): state=EMPTY, out_valid=0, in_ready=1, out_data=BUBBLE, skid reg=BUBBLE, counters=0.
//  - Accept = in_valid & in_ready; Drain = out_valid & out_ready. Evaluated at rising clk.
//  - States: EMPTY (main empty), BUSY (main full, skid empty), FULL (main+skid full).
//    in_ready = (state != FULL); out_valid = (state != EMPTY). No combinational path out_ready->in_ready.
//  - EMPTY:  Accept -> BUSY, main<=in_data. Else stay.
//  - BUSY:   Accept&Drain -> BUSY, main<=in_data; Accept&!Drain -> FULL, skid<=in_data;
//            !Accept&Drain -> EMPTY, main<=BUBBLE; neither -> stay.
//  - FULL:   Drain -> BUSY, main<=skid, skid<=BUBBLE; else stay. in_valid ignored.
//  - Latency: 1 cycle from Accept (in EMPTY) to out_valid. Strict FIFO order; no entry duplicated or lost except by flush.
//  - Throughput: 1 entry/cycle sustained while out_ready=1.
//  - Stall: out_data and out_valid held stable while out_valid & !out_ready.
//  - flush=1: highest priority. Next state EMPTY, main/skid<=BUBBLE, any Accept in the same cycle is discarded
//    (upstream is flushed by the same hazard signal). flush during FULL discards 2, BUSY 1, EMPTY 0.
//  - rst asserted mid-operation: immediate return to reset values regardless of clk, no partial update.
//
// CONFIGURATION
//  - PIPE_STAGE_STATS_EN defined: stall_cnt/flush_cnt ports and counters exist; both saturate at 2^CNT_W-1;
//    counts feed the Stats block. flush_cnt adds 0/1/2 per flush cycle per occupancy above (ignoring the dropped input).
//  - Undefined: ports and counters absent; handshake behaviour identical.
//
// STRUCTURE
//  - Package pipe_pkg: occ_state_e {EMPTY=2'b00, BUSY=2'b01, FULL=2'b11}, MIPS_NOP=32'h0000_0000 constant, default CNT_W.
//  - Sub-module pipe_sat_ctr (CNT_W, inc amount 0..2, saturating, async reset) instantiated twice under the macro.
//  - Top holds state FSM, main and skid registers, and output decode.
//
// TESTING
//  1. Reset: rst=1 with in_valid=1 -> out_valid=0, in_ready=1, out_data=0; release, push 32'hAAAA_0001 -> out next cycle.
//  2. Streaming: out_ready=1, push 8 words 1..8 back-to-back -> out 1..8 in order, one per cycle, in_ready stays 1.
//  3. Stall/skid: push A,B,C with out_ready=0 -> A held on out_data, B in skid, in_ready=0 after B, C not accepted;
//     raise out_ready -> A,B drained in order, then C accepted.
//  4. Flush in FULL with in_valid=1 (D) -> next cycle out_valid=0, out_data=0, D never emitted; flush_cnt +2 (stats build).
//  5. Stall count: hold out_ready=0 for 5 cycles with valid entry -> stall_cnt=5; with CNT_W=3 and 10 cycles -> stall_cnt=7.
//  6. Async reset in FULL between clock edges -> outputs go to reset values immediately, no edge required.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the elastic pipeline stage.
//   - occ_state_e : occupancy of a stage (EMPTY / BUSY / FULL)
//   - MIPS_NOP    : all-zero instruction used as the bubble payload
//   - DEF_DATA_W / DEF_CNT_W : default payload and statistics widths
//   - occ_count() : number of live entries held in a given occupancy state
// ---------------------------------------------------------------------------
package pipe_pkg;

    // BUSY/FULL encodings differ in one bit so "skid occupied" is state[1].
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } occ_state_e;

    localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_CNT_W  = 32;

    // Live entries held by a stage in state s (0, 1 or 2).
    function automatic logic [1:0] occ_count(input occ_state_e s);
        case (s)
            BUSY:    occ_count = 2'd1;
            FULL:    occ_count = 2'd2;
            default: occ_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_ctr.sv
// ---------------------------------------------------------------------------
// pipe_sat_ctr
//   Saturating up-counter adding 0, 1 or 2 per cycle; sticks at 2^CNT_W-1.
//
//   Ports
//     clk    in   1       clock, rising edge
//     rst    in   1       asynchronous, active-high reset (count -> 0)
//     inc_i  in   2       increment amount for this cycle (0..2)
//     cnt_o  out  CNT_W   current count
// ---------------------------------------------------------------------------
module pipe_sat_ctr
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sum;

    // One extra bit is enough: (2^W-1)+2 never overflows W+1 bits.
    assign sum = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);

    always_comb begin
        cnt_d = sum[CNT_W-1:0];
        if (sum > MAX) cnt_d = MAX[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Elastic pipeline stage register with a 2-entry skid buffer. in_ready is
//   decoded purely from the occupancy flops, so there is no combinational
//   path from out_ready back to in_ready. A synchronous flush squashes all
//   held entries and any same-cycle input. While empty the output carries
//   BUBBLE (the NOP encoding by default).
//
//   Optional feature macro: PIPE_STAGE_STATS_EN
//     defined   : adds stall_cnt / flush_cnt saturating statistics ports
//     undefined : statistics ports and counters are absent
//
//   Ports
//     clk        in   1       clock, rising edge
//     rst        in   1       asynchronous, active-high reset
//     flush      in   1       synchronous squash of held and incoming entries
//     in_valid   in   1       upstream payload valid
//     in_ready   out  1       stage can accept (state flops only)
//     in_data    in   DATA_W  upstream payload
//     out_valid  out  1       out_data holds a live entry
//     out_ready  in   1       downstream accepts (low = stall)
//     out_data   out  DATA_W  head entry, BUBBLE when out_valid=0
//     stall_cnt  out  CNT_W   [stats] cycles with out_valid & !out_ready
//     flush_cnt  out  CNT_W   [stats] live entries discarded by flush
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(MIPS_NOP),
    parameter int                CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_skid: DATA_W and CNT_W must be >= 1");
    end

    occ_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;   // head entry, drives out_data
    logic [DATA_W-1:0] skid_q, skid_d;   // second entry caught while stalled
    logic              accept, drain;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    // main_q is forced to BUBBLE whenever the stage empties, so no mux here.
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over everything, including a same-cycle accept.
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    case ({accept, drain})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end
                        2'b01: begin
                            state_d = EMPTY;
                            main_d  = BUBBLE;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so in_valid is irrelevant.
                    if (drain) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] stall_inc;
    logic [1:0] flush_inc;

    assign stall_inc = {1'b0, out_valid & ~out_ready};
    // Only held entries count; the squashed same-cycle input is not one.
    assign flush_inc = flush ? occ_count(state_q) : 2'd0;

    pipe_sat_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    pipe_sat_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
    int            exp_stall = 0;
    int            exp_flush = 0;
`endif

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] sb[$];        // reference model: entries held, head first
    int            occ_before = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model, then retires entries
    // according to the handshake that the coming edge will perform.
    always @(negedge clk) begin
        int n;
        if (mon_en) begin
            n = sb.size();
            chk("out_valid", out_valid, 64'(n > 0));
            chk("in_ready", in_ready, 64'(n < 2));
            if (n > 0) chk("out_data", out_data, sb[0]);
            else       chk("out_data_bubble", out_data, 64'd0);
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", stall_cnt, exp_stall);
            chk("flush_cnt", flush_cnt, exp_flush);
            if (n > 0 && !out_ready) exp_stall = (exp_stall < CMAX) ? exp_stall + 1 : CMAX;
            if (flush) exp_flush = (exp_flush + n > CMAX) ? CMAX : exp_flush + n;
`endif
            occ_before = n;
            if (flush) sb.delete();
            else if (n > 0 && out_ready) void'(sb.pop_front());
        end
    end

    // One cycle of stimulus: inputs were set just after a rising edge; the
    // expected entry is queued if the stage (capacity 2) should accept it.
    task automatic step();
        @(negedge clk);
        #1;
        if (mon_en && in_valid && !flush && occ_before < 2) sb.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int cycles, input int ready_pct, input int flush_pct);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(0, 99) < 75);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            flush     = ($urandom_range(0, 99) < flush_pct);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset with a valid input pending: nothing may be captured.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hAAAA_0001;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 64'd0);
        chk("rst_flush_cnt", flush_cnt, 64'd0);
`endif
        rst       = 1'b0;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // Back-to-back streaming.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Stall: A in main, B in skid, C refused until space opens.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_000A; step();
        in_data = 32'h0000_000B; step();
        in_data = 32'h0000_000C; step();
        step();
        out_ready = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        repeat (4) step();

        // Flush while FULL with a valid input D on the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_000E; step();
        in_data = 32'h0000_000F; step();
        in_data = 32'h0000_000D; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) step();

        // Long stall with one entry (drives the stall counter to saturation).
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1234_5678; step();
        in_valid = 1'b0;
        repeat (20) step();
        out_ready = 1'b1;
        repeat (2) step();

        rand_cycles(400, 80, 3);
        rand_cycles(400, 30, 8);

        // Asynchronous reset in FULL between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h5555_0001; step();
        in_data = 32'h5555_0002; step();
        in_data = 32'h5555_0003; step();
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 64'd0);
        chk("arst_in_ready", in_ready, 64'd1);
        chk("arst_out_data", out_data, 64'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("arst_stall_cnt", stall_cnt, 64'd0);
        chk("arst_flush_cnt", flush_cnt, 64'd0);
        exp_stall = 0;
        exp_flush = 0;
`endif
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        rand_cycles(200, 60, 4);
        out_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
